// File: rtl/ex_mem_stage_pkg.sv
// Shared constants and types for the EX/MEM pipeline register slice.
// DATA_W/REG_W are datapath widths, DEPTH is the skid-buffer depth,
// CTRL_* give bit positions inside the 6-bit execute control word
// {reg_write, mem_read, mem_write, mem_to_reg, branch, bne}.
package ex_mem_stage_pkg;
  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int CTRL_W  = 6;
  localparam int MCTRL_W = 4;

  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_BRANCH     = 1;
  localparam int CTRL_BNE        = 0;

  // One held entry; branch outcome is resolved before storage so the
  // memory side only sees registered values.
  typedef struct packed {
    logic [DATA_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [REG_W-1:0]   rd;
    logic [MCTRL_W-1:0] ctrl;
    logic               br_taken;
    logic [DATA_W-1:0]  br_target;
  } entry_t;

  // Word-offset branch target, wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] br_tgt(input logic [DATA_W-1:0] pc4,
                                               input logic [DATA_W-1:0] imm);
    return pc4 + (imm << 2);
  endfunction
endpackage

// File: rtl/ex_mem_fifo2.sv
// Two-entry FIFO, shift organisation: slot0 is always the head.
// Ports: clk/rst_n, push/pop (ignored when full/empty respectively),
// flush (synchronous, wins over push/pop), din/dout payload, count.
module ex_mem_fifo2
  import ex_mem_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [W-1:0]     slot0, slot1;
  logic [CNT_W-1:0] cnt;
  logic             push_ok, pop_ok;

  assign push_ok = push & (cnt != FULL);
  assign pop_ok  = pop  & (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (cnt == '0) slot0 <= din;
          else           slot1 <= din;
          cnt <= cnt + CNT_W'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - CNT_W'(1);
        end
        // Only reachable at count 1: head leaves, new entry takes its place.
        2'b11: slot0 <= din;
        default: ;
      endcase
    end
  end

  assign dout  = slot0;
  assign count = cnt;
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage register with 2-entry elastic buffering.
// Inputs: execute results (alu_out, alu_zero, store_data, pc_plus4,
// imm_ext, rd, ctrl) under in_valid/in_ready; flush discards all entries.
// Outputs: head entry (m_addr, m_wdata, m_rd, m_ctrl, br_taken, br_target)
// under out_valid/out_ready. Control outputs are masked while empty so
// no write or branch can leak from a stale slot.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_zero,
  input  logic [DATA_W-1:0]  store_data,
  input  logic [DATA_W-1:0]  pc_plus4,
  input  logic [DATA_W-1:0]  imm_ext,
  input  logic [REG_W-1:0]   rd,
  input  logic [CTRL_W-1:0]  ctrl,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  m_addr,
  output logic [DATA_W-1:0]  m_wdata,
  output logic [REG_W-1:0]   m_rd,
  output logic [MCTRL_W-1:0] m_ctrl,
  output logic               br_taken,
  output logic [DATA_W-1:0]  br_target
);
  entry_t           din, head;
  logic [CNT_W-1:0] count;
  logic             push, pop;

  // Handshakes depend only on the registered count.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    din           = '0;
    din.addr      = alu_out;
    din.wdata     = store_data;
    din.rd        = rd;
    din.ctrl      = ctrl[CTRL_REG_WRITE:CTRL_MEM_TO_REG];
    din.br_taken  = ctrl[CTRL_BRANCH] &
                    (ctrl[CTRL_BNE] ? ~alu_zero : alu_zero);
    din.br_target = br_tgt(pc_plus4, imm_ext);
  end

  ex_mem_fifo2 #(.W($bits(entry_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .count (count)
  );

  assign m_addr    = head.addr;
  assign m_wdata   = head.wdata;
  assign m_rd      = head.rd;
  assign br_target = head.br_target;
  assign m_ctrl    = out_valid ? head.ctrl : '0;
  assign br_taken  = out_valid & head.br_taken;
endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0, in_ready;
  logic [31:0] alu_out = 0, store_data = 0, pc_plus4 = 0, imm_ext = 0;
  logic        alu_zero = 0;
  logic [4:0]  rd = 0;
  logic [5:0]  ctrl = 0;
  logic        flush = 0;
  logic        out_valid, out_ready = 0;
  logic [31:0] m_addr, m_wdata, br_target;
  logic [4:0]  m_rd;
  logic [3:0]  m_ctrl;
  logic        br_taken;

  int tests = 0, fails = 0;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_zero(alu_zero), .store_data(store_data),
    .pc_plus4(pc_plus4), .imm_ext(imm_ext), .rd(rd), .ctrl(ctrl),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_ctrl(m_ctrl),
    .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, sd, pc, imm;
    logic [4:0]  rd;
    logic [5:0]  ctrl;
    logic        zero;
    logic [3:0]  e_ctrl;
    logic        e_tk;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t q[$];
  vec_t v[7];

  function automatic vec_t mk(logic [31:0] a, sd, pc, imm, logic [4:0] r,
                              logic [5:0] c, logic z, logic [3:0] ec,
                              logic et, logic [31:0] tg);
    vec_t x;
    x.alu = a; x.sd = sd; x.pc = pc; x.imm = imm; x.rd = r; x.ctrl = c;
    x.zero = z; x.e_ctrl = ec; x.e_tk = et; x.e_tgt = tg;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one entry starting just after a rising edge; record it in the
  // scoreboard on the cycle its handshake will complete.
  task automatic send(vec_t x);
    int n = 0;
    alu_out = x.alu; store_data = x.sd; pc_plus4 = x.pc; imm_ext = x.imm;
    rd = x.rd; ctrl = x.ctrl; alu_zero = x.zero; in_valid = 1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 50) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    if (in_ready) q.push_back(x);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: compare head against scoreboard front on every accepted pop,
  // and on stalled cycles (head must be held); idle masking otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          string t;
          vec_t e;
          t = out_ready ? "pop" : "stall";
          e = out_ready ? q.pop_front() : q[0];
          chk({t, "_m_addr"},    m_addr,    e.alu);
          chk({t, "_m_wdata"},   m_wdata,   e.sd);
          chk({t, "_m_rd"},      32'(m_rd),  32'(e.rd));
          chk({t, "_m_ctrl"},    32'(m_ctrl), 32'(e.e_ctrl));
          chk({t, "_br_taken"},  32'(br_taken), 32'(e.e_tk));
          chk({t, "_br_target"}, br_target, e.e_tgt);
        end
      end else begin
        chk("idle_m_ctrl", 32'(m_ctrl), 0);
        chk("idle_br_taken", 32'(br_taken), 0);
      end
    end
  end

  initial begin
    //          alu       sd        pc          imm         rd ctrl       z  ectrl   tk tgt
    v[0] = mk(32'h10,   32'h0,    32'h0,      32'h0,      3, 6'b100000, 0, 4'b1000, 0, 32'h0);
    v[1] = mk(32'h20,   32'hDEAD, 32'h40,     32'h4,      5, 6'b001000, 0, 4'b0010, 0, 32'h50);
    v[2] = mk(32'h24,   32'hBEEF, 32'h44,     32'h1,      7, 6'b110100, 0, 4'b1101, 0, 32'h48);
    v[3] = mk(32'h0,    32'h0,    32'h100,    32'hFFFFFFFF, 0, 6'b000010, 1, 4'b0000, 1, 32'hFC);
    v[4] = mk(32'h0,    32'h0,    32'h100,    32'hFFFFFFFF, 0, 6'b000011, 1, 4'b0000, 0, 32'hFC);
    v[5] = mk(32'h0,    32'h0,    32'hFFFFFFFC, 32'h2,    0, 6'b000010, 0, 4'b0000, 0, 32'h4);
    v[6] = mk(32'h1,    32'h2,    32'h200,    32'h10,     9, 6'b000011, 0, 4'b0000, 1, 32'h240);

    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready), 1);
    chk("rst_m_ctrl",    32'(m_ctrl), 0);
    chk("rst_br_taken",  32'(br_taken), 0);
    chk("rst_m_addr",    m_addr, 0);
    chk("rst_br_target", br_target, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_in_ready",  32'(in_ready), 1);
    chk("post_rst_out_valid", 32'(out_valid), 0);

    // Single pass, then back-to-back streaming (push+pop at count 1)
    out_ready = 1;
    send(v[0]);
    chk("single_latency_valid", 32'(out_valid), 1);
    send(v[3]); send(v[4]); send(v[5]); send(v[6]);
    drain();

    // Backpressure: fill, check full, then release with a pending push
    out_ready = 0;
    send(v[1]); send(v[2]);
    chk("full_in_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk); #1;
    out_ready = 1;
    send(v[6]);  // must wait a cycle: no push while full even with pop
    drain();

    // Flush at count 2 with a simultaneous push
    out_ready = 0;
    send(v[1]); send(v[2]);
    flush = 1; in_valid = 1;
    alu_out = v[0].alu; ctrl = v[0].ctrl; rd = v[0].rd;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    q.delete();
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready",  32'(in_ready), 1);
    out_ready = 1;
    repeat (3) @(posedge clk); #1;
    chk("flush_dropped", 32'(out_valid), 0);

    // Reset mid-stream with one held entry: asynchronous clear
    out_ready = 0;
    send(v[2]);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_m_ctrl",    32'(m_ctrl), 0);
    chk("midrst_in_ready",  32'(in_ready), 1);
    chk("midrst_m_addr",    m_addr, 0);
    q.delete();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("midrst_post_valid", 32'(out_valid), 0);

    // Stream resumes cleanly after reset
    out_ready = 1;
    send(v[1]);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset; clk and rst_n are listed first.
REQ-002 SHALL have port `clk`: input, 1 bit, rising-edge clock.
REQ-003 SHALL have port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port `in_valid`: input, 1 bit, upstream execute result valid.
REQ-005 SHALL have port `in_ready`: output, 1 bit, stage can accept this cycle.
REQ-006 SHALL have port `alu_out`: input, 32 bits, ALU result.
REQ-007 SHALL have port `alu_zero`: input, 1 bit, ALU zero flag.
REQ-008 SHALL have port `store_data`: input, 32 bits, rt value for stores.
REQ-009 SHALL have port `pc_plus4`: input, 32 bits, PC+4 of the instruction.
REQ-010 SHALL have port `imm_ext`: input, 32 bits, sign-extended immediate.
REQ-011 SHALL have port `rd`: input, 5 bits, destination register.
REQ-012 SHALL have port `ctrl`: input, 6 bits: {reg_write, mem_read, mem_write, mem_to_reg, branch, bne}.
REQ-013 SHALL have port `flush`: input, 1 bit, synchronous discard of all held entries.
REQ-014 SHALL have port `out_valid`: output, 1 bit, head entry valid to the memory stage.
REQ-015 SHALL have port `out_ready`: input, 1 bit, memory stage accepts.
REQ-016 SHALL have ports `m_addr` (32 bits), `m_wdata` (32 bits), `m_rd` (5 bits) and `m_ctrl` (4 bits {reg_write, mem_read, mem_write, mem_to_reg}) as outputs carrying the head entry.
REQ-017 SHALL have ports `br_taken` (1 bit) and `br_target` (32 bits) as outputs giving the head entry's branch resolution.

Function
REQ-018 SHALL buffer up to 2 entries in FIFO order; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-019 SHALL drive in_ready = (count != 2) and out_valid = (count != 0), both derived from registered state only.
REQ-020 SHALL give a minimum latency of 1 cycle: an entry pushed at edge N is visible on the outputs after edge N.
REQ-021 SHALL, on simultaneous push and pop at count 1, keep count at 1 and place the new entry at the head after the edge.
REQ-022 SHALL, at count 2, accept no push even when a pop occurs in the same cycle.
REQ-023 SHALL capture the entry's fields at push: m_addr = alu_out, m_wdata = store_data, m_rd = rd, m_ctrl = ctrl[5:2].
REQ-024 SHALL compute br_taken at push as branch & (bne ? ~alu_zero : alu_zero), stored with the entry.
REQ-025 SHALL compute br_target at push as pc_plus4 + (imm_ext << 2), modulo 2^32 (wrap-around, no overflow flag).
REQ-026 SHALL, on flush, set count to 0 at the next edge, with flush taking priority over a same-cycle push or pop.
REQ-027 SHALL hold the output fields stable while out_valid=1 and out_ready=0.
REQ-028 SHALL keep br_taken=0 whenever out_valid=0.
REQ-029 SHALL force m_ctrl=0 whenever out_valid=0, so no spurious write occurs.

Reset
REQ-030 SHALL, on rst_n low, set count to 0, out_valid to 0, in_ready to 1, br_taken to 0 and all data outputs to 0.
REQ-031 SHALL discard any in-flight entries on a reset asserted mid-operation, with no partial pop.
REQ-032 SHALL hold in_ready=1 and out_valid=0 on the first edge after reset deassertion.

Structure
REQ-033 SHALL take its constants from a shared package: DATA_W=32, REG_W=5, the CTRL bit positions, and the DEPTH=2 constant.
REQ-034 SHALL implement the storage as one sub-module, ex_mem_fifo2 (2-entry FIFO: payload width parameter, push/pop/flush, count); branch logic sits in the parent.

Verification
REQ-035 SHALL check a single pass: push alu_out=0x10, rd=3, ctrl=6'b100000, out_ready=1 -> next cycle out_valid=1, m_addr=0x10, m_rd=3, m_ctrl=4'b1000.
REQ-036 SHALL check backpressure: out_ready=0, push A then B -> in_ready=0 after B; release -> A then B in order, each held stable while stalled.
REQ-037 SHALL check branch resolution: branch=1, bne=0, alu_zero=1, pc_plus4=0x100, imm_ext=0xFFFFFFFF -> br_taken=1, br_target=0xFC; the same with bne=1 -> br_taken=0.
REQ-038 SHALL check wrap-around: pc_plus4=0xFFFFFFFC, imm_ext=2 -> br_target=0x00000004.
REQ-039 SHALL check flush: count=2 with flush and in_valid both asserted -> next cycle out_valid=0, count=0, new entry dropped.
REQ-040 SHALL check reset mid-stream: rst_n low with count=1 -> out_valid=0 and m_ctrl=0 immediately, without waiting for a clock edge.
